// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// prog_loader: assembles 16-bit program words (high byte first) from a byte stream
// and writes them into a 32x16 CPU memory, holding the CPU off (wm) while loading.
module prog_loader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        cpuClk,
  input  logic        cpuRst,
  input  logic        start,
  input  logic [5:0]  wordCount,
  input  logic [7:0]  inData,
  input  logic        inValid,
  output logic        inReady,
  output logic        memWe,
  output logic [4:0]  memAddr,
  output logic [15:0] memData,
  output logic        wm,
  output logic        loadDone,
  output logic        loadErr
);

  localparam int unsigned IdleW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE, ERR} state_e;

  state_e           state_q, state_d;
  logic [4:0]       addr_q, addr_d;
  logic [5:0]       count_q, count_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       lo_q, lo_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             ready_q, we_q, wm_q, done_q, err_q;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    idle_d  = idle_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          addr_d  = '0;
          idle_d  = '0;
          count_d = (wordCount > 6'd32) ? 6'd32 : wordCount;
          state_d = (wordCount == 6'd0) ? DONE : HI;
        end
      end
      HI, LO: begin
        if (inValid) begin
          idle_d = '0;
          if (state_q == HI) begin
            hi_d    = inData;
            state_d = LO;
          end else begin
            lo_d    = inData;
            state_d = WRITE;
          end
        end else if (idle_q == IdleMax) begin
          state_d = ERR;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
      end
      WRITE: begin
        if (({1'b0, addr_q} + 6'd1) == count_q) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 5'd1;
          idle_d  = '0;
          state_d = HI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered output flags decoded from the next state
  always_ff @(posedge cpuClk or posedge cpuRst) begin
    if (cpuRst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      idle_q  <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      wm_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      idle_q  <= idle_d;
      ready_q <= (state_d == HI) || (state_d == LO);
      we_q    <= (state_d == WRITE);
      wm_q    <= (state_d == HI) || (state_d == LO) || (state_d == WRITE);
      done_q  <= (state_d == DONE);
      err_q   <= (state_d == ERR);
    end
  end

  assign inReady  = ready_q;
  assign memWe    = we_q;
  assign memAddr  = addr_q;
  assign memData  = {hi_q, lo_q};
  assign wm       = wm_q;
  assign loadDone = done_q;
  assign loadErr  = err_q;

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
// Bench for prog_loader: directed vector table, reset/timeout/clamp sequences and
// randomized loads checked against a byte-count based reference model.
module tb_prog_loader;
  localparam int unsigned TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  wc;
  logic [7:0]  din;
  logic        vin;
  logic        inReady, memWe, wm, loadDone, loadErr;
  logic [4:0]  memAddr;
  logic [15:0] memData;

  always #5 clk = ~clk;

  prog_loader #(.TIMEOUT(TIMEOUT)) dut (
    .cpuClk(clk), .cpuRst(rst), .start(start), .wordCount(wc),
    .inData(din), .inValid(vin), .inReady(inReady), .memWe(memWe),
    .memAddr(memAddr), .memData(memData), .wm(wm),
    .loadDone(loadDone), .loadErr(loadErr)
  );

  int n_vec, n_err, dut_writes;
  logic [15:0] dmem [32];
  logic [15:0] emem [32];

  // Reference model: progress tracked as bytes received and a pending-write flag
  bit   m_active, m_bubble, m_done, m_err;
  int   m_nbytes, m_count, m_addr, m_idle;
  logic [7:0] m_hi, m_lo;

  typedef struct {
    logic s; logic [5:0] w; logic v; logic [7:0] d;
    logic rdy; logic we; logic wm_e; logic done; logic [4:0] addr; logic [15:0] data;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_bubble = 0; m_done = 0; m_err = 0;
    m_nbytes = 0; m_count = 0; m_addr = 0; m_idle = 0;
    m_hi = 8'h00; m_lo = 8'h00;
  endtask

  task automatic model_step(input logic s, input logic [5:0] w, input logic v, input logic [7:0] d);
    if (m_bubble) begin
      emem[m_addr] = {m_hi, m_lo};
      m_bubble = 0;
      if (m_addr == m_count - 1) begin
        m_active = 0; m_done = 1;
      end else begin
        m_addr++; m_idle = 0;
      end
    end else if (m_active) begin
      if (v) begin
        if (m_nbytes % 2 == 0) m_hi = d;
        else begin m_lo = d; m_bubble = 1; end
        m_nbytes++; m_idle = 0;
      end else if (m_idle == int'(TIMEOUT)) begin
        m_active = 0; m_err = 1;
      end else begin
        m_idle++;
      end
    end else if (s) begin
      m_addr = 0; m_done = 0; m_err = 0; m_idle = 0; m_nbytes = 0;
      m_count = (int'(w) > 32) ? 32 : int'(w);
      if (w == 6'd0) m_done = 1;
      else m_active = 1;
    end
  endtask

  task automatic note_write();
    if (memWe === 1'b1) begin
      dmem[memAddr] = memData;
      dut_writes++;
    end
  endtask

  task automatic check_model();
    chk("inReady",  32'(inReady),  32'(m_active && !m_bubble));
    chk("memWe",    32'(memWe),    32'(m_bubble));
    chk("wm",       32'(wm),       32'(m_active));
    chk("memAddr",  32'(memAddr),  32'(m_addr));
    chk("memData",  32'(memData),  32'({m_hi, m_lo}));
    chk("loadDone", 32'(loadDone), 32'(m_done));
    chk("loadErr",  32'(loadErr),  32'(m_err));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".inReady"},  32'(inReady),  32'd0);
    chk({tag, ".memWe"},    32'(memWe),    32'd0);
    chk({tag, ".memAddr"},  32'(memAddr),  32'd0);
    chk({tag, ".memData"},  32'(memData),  32'd0);
    chk({tag, ".wm"},       32'(wm),       32'd0);
    chk({tag, ".loadDone"}, 32'(loadDone), 32'd0);
    chk({tag, ".loadErr"},  32'(loadErr),  32'd0);
  endtask

  task automatic step(input logic s, input logic [5:0] w, input logic v, input logic [7:0] d);
    start = s; wc = w; vin = v; din = d;
    model_step(s, w, v, d);
    @(posedge clk);
    @(negedge clk);
    note_write();
    check_model();
  endtask

  // Asserts reset between clock edges so the outputs must clear asynchronously
  task automatic do_reset();
    #2;
    rst = 1'b1; start = 1'b0; vin = 1'b0;
    #1;
    check_zero("reset_async");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_load(input logic [5:0] w, input int pct, input int max_bytes);
    int sent, cyc;
    logic v, s, rdy;
    sent = 0; cyc = 0;
    step(1'b1, w, 1'b0, 8'h00);
    while (m_active && cyc < 2000) begin
      v   = (sent < max_bytes) && ($urandom_range(99) < pct);
      s   = ($urandom_range(19) == 0);
      rdy = m_active && !m_bubble;
      if (v && rdy) sent++;
      step(s, 6'($urandom_range(63)), v, 8'($urandom_range(255)));
      cyc++;
    end
    chk("load_cycle_bound", 32'(m_active), 32'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("mem[%0d]", i), 32'(dmem[i]), 32'(emem[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int w0;
    n_vec = 0; n_err = 0; dut_writes = 0;
    for (int i = 0; i < 32; i++) begin dmem[i] = 16'h0; emem[i] = 16'h0; end
    rst = 1'b1; start = 1'b0; wc = 6'd0; vin = 1'b0; din = 8'h00;

    // s, w, v, d | inReady, memWe, wm, loadDone, memAddr, memData
    tbl[0]  = '{1'b1, 6'd2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 16'h0000};
    tbl[1]  = '{1'b0, 6'd0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 16'hA500};
    tbl[2]  = '{1'b0, 6'd0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 16'hA55A};
    tbl[3]  = '{1'b0, 6'd0, 1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 16'hA55A};
    tbl[4]  = '{1'b0, 6'd0, 1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 16'h125A};
    tbl[5]  = '{1'b0, 6'd0, 1'b1, 8'h34, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 16'h1234};
    tbl[6]  = '{1'b0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 16'h1234};
    tbl[7]  = '{1'b0, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 16'h1234};
    tbl[8]  = '{1'b1, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 16'h1234};
    tbl[9]  = '{1'b1, 6'd1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 16'h1234};
    tbl[10] = '{1'b1, 6'd5, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 16'h7734};
    tbl[11] = '{1'b1, 6'd5, 1'b1, 8'h88, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 16'h7788};
    tbl[12] = '{1'b1, 6'd5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 16'h7788};
    tbl[13] = '{1'b1, 6'd1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 16'h7788};

    #12;
    check_zero("reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Basic load, zero-length load, ignored start and restart
    for (int i = 0; i < 14; i++) begin
      start = tbl[i].s; wc = tbl[i].w; vin = tbl[i].v; din = tbl[i].d;
      model_step(tbl[i].s, tbl[i].w, tbl[i].v, tbl[i].d);
      @(posedge clk);
      @(negedge clk);
      note_write();
      chk($sformatf("tbl%0d.inReady", i),  32'(inReady),  32'(tbl[i].rdy));
      chk($sformatf("tbl%0d.memWe", i),    32'(memWe),    32'(tbl[i].we));
      chk($sformatf("tbl%0d.wm", i),       32'(wm),       32'(tbl[i].wm_e));
      chk($sformatf("tbl%0d.loadDone", i), 32'(loadDone), 32'(tbl[i].done));
      chk($sformatf("tbl%0d.loadErr", i),  32'(loadErr),  32'd0);
      chk($sformatf("tbl%0d.memAddr", i),  32'(memAddr),  32'(tbl[i].addr));
      chk($sformatf("tbl%0d.memData", i),  32'(memData),  32'(tbl[i].data));
    end
    chk("tbl.mem0", 32'(dmem[0]), 32'h7788);
    chk("tbl.mem1", 32'(dmem[1]), 32'h1234);

    // Reset while the low byte of word 1 is awaited
    do_reset();
    step(1'b1, 6'd2, 1'b0, 8'h00);
    step(1'b0, 6'd0, 1'b1, 8'hC1);
    step(1'b0, 6'd0, 1'b1, 8'hC2);
    step(1'b0, 6'd0, 1'b0, 8'h00);
    step(1'b0, 6'd0, 1'b1, 8'hC3);
    w0 = dut_writes;
    do_reset();
    step(1'b0, 6'd0, 1'b1, 8'hC4);
    chk("reset_no_write", 32'(dut_writes - w0), 32'd0);
    chk("reset_keeps_mem0", 32'(dmem[0]), 32'hC1C2);
    run_load(6'd2, 100, 4);

    // Timeout after a word and a half
    do_reset();
    w0 = dut_writes;
    run_load(6'd3, 100, 3);
    chk("timeout_writes", 32'(dut_writes - w0), 32'd1);
    chk("timeout_err", 32'(loadErr), 32'd1);
    chk("timeout_wm", 32'(wm), 32'd0);

    // Clamp to 32 words, then stay not-ready
    w0 = dut_writes;
    run_load(6'd40, 100, 64);
    chk("clamp_writes", 32'(dut_writes - w0), 32'd32);
    chk("clamp_last_addr", 32'(memAddr), 32'd31);
    for (int i = 0; i < 3; i++) step(1'b0, 6'd0, 1'b1, 8'hEE);

    // Gapped input and random loads
    run_load(6'd2, 50, 4);
    for (int n = 0; n < 12; n++)
      run_load(6'($urandom_range(40)), 50 + int'($urandom_range(50)), 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have the parameter TIMEOUT, default 255, meaning the maximum number of idle cycles allowed between accepted bytes.
REQ-002 The block SHALL have the port cpuClk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have the port cpuRst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The block SHALL have the port start, input, 1 bit: a one-cycle request to begin a load.
REQ-005 The block SHALL have the port wordCount, input, 6 bits: the number of 16-bit words to load, sampled on the accepted start.
REQ-006 The block SHALL have the port inData, input, 8 bits: the incoming program byte.
REQ-007 The block SHALL have the port inValid, input, 1 bit: inData is valid.
REQ-008 The block SHALL have the port inReady, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 The block SHALL have the port memWe, output, 1 bit: the write strobe to the 32x16 CPU memory.
REQ-010 The block SHALL have the port memAddr, output, 5 bits: the memory write address.
REQ-011 The block SHALL have the port memData, output, 16 bits: the memory write data.
REQ-012 The block SHALL have the port wm, output, 1 bit: CPU write mode, which holds the CPU off memory while a load is in progress.
REQ-013 The block SHALL have the port loadDone, output, 1 bit: the load completed.
REQ-014 The block SHALL have the port loadErr, output, 1 bit: the load aborted on timeout.

Function
REQ-015 The FSM SHALL have the states IDLE, HI, LO, WRITE, DONE and ERR.
REQ-016 start SHALL be accepted only in IDLE, DONE or ERR; start SHALL be ignored in HI, LO and WRITE.
REQ-017 On an accepted start: addr<=0, count latched, loadDone<=0, loadErr<=0, idle counter<=0.
- count = min(wordCount, 32).
- wordCount=0 SHALL go directly to DONE with no write.
- Otherwise the FSM SHALL go to HI.
REQ-018 inReady SHALL be 1 only in HI and LO.
REQ-019 A byte SHALL be accepted in any cycle where inValid and inReady are both 1.
REQ-020 inValid without inReady SHALL be ignored, with no side effects.
REQ-021 In HI, an accepted byte SHALL be stored as hi[7:0], and the FSM SHALL go to LO.
REQ-022 In LO, an accepted byte SHALL be stored as lo[7:0], and the FSM SHALL go to WRITE.
REQ-023 In WRITE, for exactly one cycle:
- memWe=1.
- memAddr=addr.
- memData={hi,lo} (high byte first).
REQ-024 The write SHALL occur in the cycle after the low byte is accepted (1-cycle latency); inReady SHALL be 0 in WRITE.
REQ-025 On leaving WRITE:
- If addr==count-1, the FSM SHALL go to DONE.
- Otherwise addr SHALL increment and the FSM SHALL go to HI.
- addr SHALL never wrap past 31.
REQ-026 memWe SHALL be 0 in every state other than WRITE; memAddr SHALL show addr and memData SHALL show {hi,lo} at all times.
REQ-027 wm SHALL be 1 in HI, LO and WRITE, and 0 otherwise.
REQ-028 loadDone SHALL be 1 in DONE and SHALL hold until the next accepted start or reset.
REQ-029 loadErr SHALL be 1 in ERR and SHALL hold until the next accepted start or reset.
REQ-030 The idle counter SHALL increment on each cycle in HI or LO with no accepted byte.
- It SHALL clear on every accepted byte and on every entry to HI.
REQ-031 When the idle counter reaches TIMEOUT, the FSM SHALL go to ERR on the next edge and SHALL not write the partial word.
REQ-032 A byte accepted in the same cycle the counter reaches TIMEOUT SHALL take priority, and no error SHALL occur.
REQ-033 Words already written before an ERR SHALL remain in memory; the loader SHALL not roll them back.

Reset
REQ-034 cpuRst=1 SHALL asynchronously force the following:
- state=IDLE; addr=0; hi=0; lo=0; idle counter=0.
- inReady=0, memWe=0, memAddr=0, memData=0, wm=0, loadDone=0, loadErr=0.
REQ-035 Reset asserted mid-load SHALL abort the load immediately with no further memWe; memory contents already written SHALL be unaffected.
REQ-036 After reset deasserts, the block SHALL idle until start.

Verification
REQ-037 Basic load: start with wordCount=2, then bytes 0xA5,0x5A,0x12,0x34 with inValid=1 continuously -> memWe pulses writing addr0=0xA55A and addr1=0x1234; wm=1 from the cycle after start through the last WRITE; loadDone=1 after the last WRITE.
REQ-038 Backpressure/gaps: same load with inValid toggled 1-0-1 -> identical writes; no byte is double-captured.
REQ-039 Full and clamp: wordCount=40 with 64 bytes -> 32 writes to addr 0..31; DONE entered after addr31; inReady=0 afterward.
REQ-040 Timeout: TIMEOUT=255, start with wordCount=3, send 3 bytes then stop -> exactly one write (addr0), then after 255 idle cycles loadErr=1 and wm=0.
REQ-041 Reset mid-load: assert cpuRst during LO of word 1 -> all outputs 0 immediately; a new start then loads from addr0.
REQ-042 Zero and restart: wordCount=0 -> loadDone=1 with no memWe; a start while in HI is ignored; a start in DONE clears loadDone and begins a new load.
